// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//
// Pipelined barrel shifter for any power-of-two WIDTH (>= 2). Stage k
// shifts by 2^k when bit k of the amount is set, so a full shift of
// 0..WIDTH-1 takes SW = log2(WIDTH) register stages. Modes are LSL, LSR,
// ASR and ROL. A valid/ready handshake wraps the pipe. The whole pipe
// advances together whenever the output register is empty or being taken.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (combinational)
//   in_data    operand, WIDTH bits
//   in_amt     shift amount, SW bits
//   in_mode    00 LSL, 01 LSR, 10 ASR, 11 ROL
//   out_valid  result beat valid
//   out_ready  consumer takes the result this cycle
//   out_data   shifted result
//   out_mode   mode that produced out_data
//   out_zero   out_data == 0, registered alongside the last stage
module barrel_shifter_pipe #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode,
    output logic             out_zero
);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    // Per-stage pipeline registers; index k is the output of stage k.
    logic [WIDTH-1:0] data_reg  [SW];
    logic [SW-1:0]    amt_reg   [SW];
    logic [1:0]       mode_reg  [SW];
    logic             valid_reg [SW];
    logic             zero_reg;

    // Single advance enable for the whole pipe: move when the output slot
    // is empty or is being consumed. Bubbles move too, they are not collapsed.
    logic adv;

    assign out_valid = valid_reg[SW-1];
    assign out_data  = data_reg[SW-1];
    assign out_mode  = mode_reg[SW-1];
    assign out_zero  = zero_reg;
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    // One fixed-distance shift. For ASR the fill comes from the current MSB;
    // earlier stages never change the MSB in ASR mode, so it is still the
    // operand's original sign bit.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input int               s
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            MODE_LSL: r = d << s;
            MODE_LSR: r = d >> s;
            MODE_ASR: r = $signed(d) >>> s;
            default:  r = (d << s) | (d >> (WIDTH - s));
        endcase
        return r;
    endfunction

    for (genvar gi = 0; gi < SW; gi++) begin : g_stage
        localparam int S = 1 << gi;

        logic [WIDTH-1:0] src_data;
        logic [SW-1:0]    src_amt;
        logic [1:0]       src_mode;
        logic             src_valid;
        logic [WIDTH-1:0] data_next;

        if (gi == 0) begin : g_src_in
            // adv == in_ready here, so in_valid alone decides beat vs bubble.
            assign src_data  = in_data;
            assign src_amt   = in_amt;
            assign src_mode  = in_mode;
            assign src_valid = in_valid;
        end else begin : g_src_prev
            assign src_data  = data_reg[gi-1];
            assign src_amt   = amt_reg[gi-1];
            assign src_mode  = mode_reg[gi-1];
            assign src_valid = valid_reg[gi-1];
        end

        assign data_next = src_amt[gi] ? shift_by(src_data, src_mode, S) : src_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_reg[gi]  <= '0;
                amt_reg[gi]   <= '0;
                mode_reg[gi]  <= '0;
                valid_reg[gi] <= 1'b0;
            end else if (adv) begin
                data_reg[gi]  <= data_next;
                amt_reg[gi]   <= src_amt;
                mode_reg[gi]  <= src_mode;
                valid_reg[gi] <= src_valid;
            end
        end

        if (gi == SW - 1) begin : g_zero
            // Zero flag computed from the last stage's next value so it is
            // a flop output, aligned with out_data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    zero_reg <= 1'b0;
                end else if (adv) begin
                    zero_reg <= (data_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Testbench for barrel_shifter_pipe: three instances (WIDTH 8, 16, 32)
// driven from one process. A ring-buffer scoreboard per instance holds the
// expected results of accepted beats; a reference shift computed with plain
// arithmetic on the whole amount provides expectations for random traffic.
module tb_barrel_shifter_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [63:0] in_data_a   [3];
    logic [4:0]  in_amt_a    [3];
    logic [1:0]  in_mode_a   [3];
    logic        in_valid_a  [3];
    logic        out_ready_a [3];

    wire         in_ready_w  [3];
    wire         out_valid_w [3];
    wire  [63:0] out_data_w  [3];
    wire  [1:0]  out_mode_w  [3];
    wire         out_zero_w  [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int W = 8 << gi;
        localparam int S = $clog2(W);
        logic [W-1:0] od;

        barrel_shifter_pipe #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[gi]),
            .in_ready  (in_ready_w[gi]),
            .in_data   (in_data_a[gi][W-1:0]),
            .in_amt    (in_amt_a[gi][S-1:0]),
            .in_mode   (in_mode_a[gi]),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready_a[gi]),
            .out_data  (od),
            .out_mode  (out_mode_w[gi]),
            .out_zero  (out_zero_w[gi])
        );

        assign out_data_w[gi] = 64'(od);
    end

    typedef struct {
        logic [63:0] d;
        logic [1:0]  m;
        int          acc;
    } beat_t;

    typedef struct {
        logic [7:0] d;
        int         amt;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    int wid [3] = '{8, 16, 32};
    int swv [3] = '{3, 4, 5};

    beat_t       ring [3][64];
    int          wr [3];
    int          rd [3];
    int          acc_cnt [3];
    int          xfer_cnt [3];
    logic [63:0] pend [3];
    logic        hold_v [3];
    logic [63:0] hold_d [3];
    logic [1:0]  hold_m [3];
    logic        hold_z [3];
    logic        chk_lat;
    int          cyc;
    int          total;
    int          bad;
    vec_t        vt [13];

    // Reference: whole shift applied at once with ordinary arithmetic.
    function automatic logic [63:0] ref_shift(input logic [63:0] din, input int w,
                                              input int a, input logic [1:0] m);
        logic [63:0] mask, d, r;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        d = din & mask;
        case (m)
            2'd0: r = (d << a) & mask;
            2'd1: r = d >> a;
            2'd2: begin
                r = d >> a;
                if (d[w-1]) r = r | (mask & ~(mask >> a));
            end
            default: r = (a == 0) ? d : (((d << a) | (d >> (w - a))) & mask);
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input int i, input logic [63:0] d, input int a,
                         input logic [1:0] m, input logic v);
        in_data_a[i]  = d;
        in_amt_a[i]   = 5'(a);
        in_mode_a[i]  = m;
        in_valid_a[i] = v;
        pend[i]       = ref_shift(d, wid[i], a, m);
    endtask

    // Observe handshakes at the falling edge, while inputs are stable.
    task automatic mon();
        for (int i = 0; i < 3; i++) begin
            if (in_valid_a[i] && in_ready_w[i]) begin
                ring[i][wr[i] % 64] = '{d: pend[i], m: in_mode_a[i], acc: cyc};
                wr[i]++;
                acc_cnt[i]++;
            end
            if (hold_v[i] && !out_valid_w[i])
                chk($sformatf("w%0d_valid_dropped", wid[i]), 64'(out_valid_w[i]), 64'd1);
            if (out_valid_w[i]) begin
                if (hold_v[i]) begin
                    chk($sformatf("w%0d_hold_data", wid[i]), out_data_w[i], hold_d[i]);
                    chk($sformatf("w%0d_hold_mode", wid[i]), 64'(out_mode_w[i]), 64'(hold_m[i]));
                    chk($sformatf("w%0d_hold_zero", wid[i]), 64'(out_zero_w[i]), 64'(hold_z[i]));
                end
                if (out_ready_a[i]) begin
                    hold_v[i] = 1'b0;
                    if (rd[i] == wr[i]) begin
                        chk($sformatf("w%0d_spurious_out", wid[i]), 64'd1, 64'd0);
                    end else begin
                        beat_t b;
                        b = ring[i][rd[i] % 64];
                        rd[i]++;
                        xfer_cnt[i]++;
                        $display("xfer w=%0d data=0x%0h mode=%0d zero=%0d cycle=%0d",
                                 wid[i], out_data_w[i], out_mode_w[i], out_zero_w[i], cyc);
                        chk($sformatf("w%0d_data", wid[i]), out_data_w[i], b.d);
                        chk($sformatf("w%0d_mode", wid[i]), 64'(out_mode_w[i]), 64'(b.m));
                        chk($sformatf("w%0d_zero", wid[i]), 64'(out_zero_w[i]), 64'(b.d == 64'd0));
                        if (chk_lat)
                            chk($sformatf("w%0d_latency", wid[i]), 64'(cyc - b.acc), 64'(swv[i]));
                    end
                end else begin
                    hold_v[i] = 1'b1;
                    hold_d[i] = out_data_w[i];
                    hold_m[i] = out_mode_w[i];
                    hold_z[i] = out_zero_w[i];
                end
            end else begin
                hold_v[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) in_valid_a[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle_all();
        for (int i = 0; i < 3; i++) out_ready_a[i] = 1'b1;
        while (n < 100 && (rd[0] != wr[0] || rd[1] != wr[1] || rd[2] != wr[2])) begin
            step();
            n++;
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("w%0d_drain_left", wid[i]), 64'(wr[i] - rd[i]), 64'd0);
    endtask

    task automatic flush_sb();
        for (int i = 0; i < 3; i++) begin
            rd[i]     = wr[i];
            hold_v[i] = 1'b0;
        end
    endtask

    initial begin
        int a0;
        int x0;
        logic [63:0] bpd [5];

        total = 0;
        bad = 0;
        cyc = 0;
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr[i] = 0; rd[i] = 0; acc_cnt[i] = 0; xfer_cnt[i] = 0;
            hold_v[i] = 1'b0; hold_d[i] = '0; hold_m[i] = '0; hold_z[i] = 1'b0;
            pend[i] = '0; out_ready_a[i] = 1'b1;
            drive(i, 64'd0, 0, 2'd0, 1'b0);
        end

        vt[0]  = '{d: 8'h80, amt: 4, mode: 2'd0, exp: 8'h00};
        vt[1]  = '{d: 8'h80, amt: 4, mode: 2'd1, exp: 8'h08};
        vt[2]  = '{d: 8'h80, amt: 2, mode: 2'd2, exp: 8'hE0};
        vt[3]  = '{d: 8'h80, amt: 1, mode: 2'd3, exp: 8'h01};
        vt[4]  = '{d: 8'hA5, amt: 0, mode: 2'd0, exp: 8'hA5};
        vt[5]  = '{d: 8'hA5, amt: 0, mode: 2'd1, exp: 8'hA5};
        vt[6]  = '{d: 8'hA5, amt: 0, mode: 2'd2, exp: 8'hA5};
        vt[7]  = '{d: 8'hA5, amt: 0, mode: 2'd3, exp: 8'hA5};
        vt[8]  = '{d: 8'h80, amt: 7, mode: 2'd2, exp: 8'hFF};
        vt[9]  = '{d: 8'h81, amt: 7, mode: 2'd3, exp: 8'hC0};
        vt[10] = '{d: 8'h80, amt: 7, mode: 2'd1, exp: 8'h01};
        vt[11] = '{d: 8'h7F, amt: 3, mode: 2'd2, exp: 8'h0F};
        vt[12] = '{d: 8'h01, amt: 7, mode: 2'd0, exp: 8'h80};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid_w[0]), 64'd0);
        chk("rst_out_data", out_data_w[0], 64'd0);
        chk("rst_out_mode", 64'(out_mode_w[0]), 64'd0);
        chk("rst_out_zero", 64'(out_zero_w[0]), 64'd0);
        chk("rst_in_ready", 64'(in_ready_w[0]), 64'd1);
        chk("rst_w32_out_valid", 64'(out_valid_w[2]), 64'd0);

        // Table vectors, back to back, consumer always ready
        for (int k = 0; k < 13; k++) begin
            drive(0, 64'(vt[k].d), vt[k].amt, vt[k].mode, 1'b1);
            pend[0] = 64'(vt[k].exp);
            step();
        end
        drain();

        // Backpressure: consumer stalled from the start
        chk_lat = 1'b0;
        out_ready_a[0] = 1'b0;
        a0 = acc_cnt[0];
        x0 = xfer_cnt[0];
        for (int j = 0; j < 5; j++) bpd[j] = 64'(8'h11 * (j + 1));
        for (int c = 0; c < 8; c++) begin
            if (acc_cnt[0] - a0 < 5) drive(0, bpd[acc_cnt[0] - a0], 1, 2'd0, 1'b1);
            else in_valid_a[0] = 1'b0;
            step();
        end
        chk("bp_accepted", 64'(acc_cnt[0] - a0), 64'd3);
        chk("bp_in_ready", 64'(in_ready_w[0]), 64'd0);
        chk("bp_out_valid", 64'(out_valid_w[0]), 64'd1);
        chk("bp_first_data", out_data_w[0], 64'h22);
        out_ready_a[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (acc_cnt[0] - a0 < 5) drive(0, bpd[acc_cnt[0] - a0], 1, 2'd0, 1'b1);
            else in_valid_a[0] = 1'b0;
            step();
        end
        drain();
        chk("bp_delivered", 64'(xfer_cnt[0] - x0), 64'd5);

        // Bubbles: beats in cycles 0 and 2 only
        chk_lat = 1'b1;
        drive(0, 64'h3C, 2, 2'd0, 1'b1);
        step();
        in_valid_a[0] = 1'b0;
        step();
        drive(0, 64'hC3, 3, 2'd3, 1'b1);
        step();
        in_valid_a[0] = 1'b0;
        chk("bubble_c3_valid", 64'(out_valid_w[0]), 64'd1);
        step();
        chk("bubble_c4_valid", 64'(out_valid_w[0]), 64'd0);
        step();
        chk("bubble_c5_valid", 64'(out_valid_w[0]), 64'd1);
        drain();

        // Asynchronous reset while a result is held under backpressure
        out_ready_a[0] = 1'b0;
        drive(0, 64'h5A, 1, 2'd1, 1'b1);
        step();
        in_valid_a[0] = 1'b0;
        repeat (3) step();
        chk("held_before_rst", 64'(out_valid_w[0]), 64'd1);
        #2;
        rst = 1'b1;
        flush_sb();
        #1;
        chk("arst_out_valid", 64'(out_valid_w[0]), 64'd0);
        chk("arst_out_data", out_data_w[0], 64'd0);
        chk("arst_out_zero", 64'(out_zero_w[0]), 64'd0);
        chk("arst_in_ready", 64'(in_ready_w[0]), 64'd1);
        out_ready_a[0] = 1'b1;
        step();
        rst = 1'b0;

        // Reset with two beats in flight, before any output
        x0 = xfer_cnt[0];
        drive(0, 64'hF0, 4, 2'd1, 1'b1);
        step();
        drive(0, 64'h0F, 4, 2'd0, 1'b1);
        step();
        in_valid_a[0] = 1'b0;
        #2;
        rst = 1'b1;
        flush_sb();
        #1;
        chk("midrst_out_valid", 64'(out_valid_w[0]), 64'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("midrst_no_stale", 64'(out_valid_w[0]), 64'd0);
            step();
        end
        chk("midrst_no_xfer", 64'(xfer_cnt[0] - x0), 64'd0);
        drive(0, 64'h96, 5, 2'd2, 1'b1);
        step();
        in_valid_a[0] = 1'b0;
        step();
        step();
        chk("post_rst_valid", 64'(out_valid_w[0]), 64'd1);
        chk("post_rst_data", out_data_w[0], 64'hFC);
        drain();

        // Random traffic on all widths with random backpressure
        chk_lat = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                drive(i, {$urandom(), $urandom()}, int'($urandom_range(0, wid[i] - 1)),
                      2'($urandom_range(0, 3)), $urandom_range(0, 9) < 8);
                out_ready_a[i] = $urandom_range(0, 9) < 7;
            end
            step();
        end
        drain();

        // Random traffic, consumer always ready: latency must equal SW
        chk_lat = 1'b1;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < 3; i++)
                drive(i, {$urandom(), $urandom()}, int'($urandom_range(0, wid[i] - 1)),
                      2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
